// File: rtl/npc_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state type, reset constants and next-pc helpers.
package npc_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StFault
  } ifu_state_t;

  localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NPC_INST_NOP = 32'h0000_0013;

  // Sequential pc wraps naturally at 2^32.
  function automatic logic [31:0] npc_next_pc(input logic        redirect,
                                              input logic [31:0] target,
                                              input logic [31:0] pc);
    return redirect ? target : pc + 32'd4;
  endfunction

  function automatic logic npc_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch unit bus bundle: instruction memory request/response plus decode handshake.
// The master modport is the fetch unit; slave is memory/decode/execute.
interface ifu_if;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;

  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output inst_valid, inst, inst_pc,
    input  inst_ready, redirect_valid, redirect_pc,
    output fetch_fault, fetch_count
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  inst_valid, inst, inst_pc,
    output inst_ready, redirect_valid, redirect_pc,
    input  fetch_fault, fetch_count
  );

endinterface

// File: rtl/ifu.sv
// Single-outstanding instruction fetch unit: request, wait, hold for decode, or fault.
// One instruction in flight at a time; redirects are taken only on the decode handshake.
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = NPC_RESET_PC
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] count_q, count_d;

  logic        req_valid;
  logic        hold_valid;
  logic        fault;
  logic        handshake;
  logic        bad_target;

  assign handshake  = (state_q == StHold) && bus.inst_ready;
  assign bad_target = bus.redirect_valid && npc_misaligned(bus.redirect_pc[1:0]);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    count_d    = count_q;
    req_valid  = 1'b0;
    hold_valid = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      StReq: begin
        req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.mem_rsp_valid) begin
          if (bus.mem_rsp_err) begin
            state_d = StFault;
          end else begin
            inst_d    = bus.mem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        hold_valid = 1'b1;
        if (handshake) begin
          count_d = count_q + 32'd1;
          pc_d    = npc_next_pc(bus.redirect_valid, bus.redirect_pc, pc_q);
          // inst_pc is left alone so a misaligned-target fault points at the jump.
          state_d = bad_target ? StFault : StReq;
        end
      end
      StFault: begin
        fault = 1'b1;
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      inst_q    <= NPC_INST_NOP;
      inst_pc_q <= RESET_PC;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      count_q   <= count_d;
    end
  end

  // Request and instruction valids are suppressed while reset is held.
  assign bus.mem_req_valid = req_valid & ~rst;
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = hold_valid & ~rst;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.fetch_fault   = fault;
  assign bus.fetch_count   = count_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: table of fetch transactions plus reset/fault sequences.
// Fetched words go into a scoreboard at request acceptance and are checked at handshake.
module tb_ifu;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_if bus();

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [31:0] exp_addr;
    int          req_stall;
    int          rsp_wait;
    int          hold_stall;
    bit          redir;
    logic [31:0] rpc;
    logic [31:0] data;
    bit          exp_fault;
    bit          stray;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];
  vec_t v0;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.mem_rsp_err    = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  task automatic fetch_one(input vec_t v);
    sb_t e;
    check("req_valid", bus.mem_req_valid, 1);
    check("req_addr", bus.mem_req_addr, v.exp_addr);
    check("req_no_inst", bus.inst_valid, 0);
    // Back-pressure with a spurious response that must be ignored.
    for (int i = 0; i < v.req_stall; i++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD_BEEF;
      step();
      check("stall_valid", bus.mem_req_valid, 1);
      check("stall_addr", bus.mem_req_addr, v.exp_addr);
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    sb_q.push_back('{pc: v.exp_addr, data: v.data});
    step();
    bus.mem_req_ready = 1'b0;
    check("wait_no_req", bus.mem_req_valid, 0);
    check("wait_no_inst", bus.inst_valid, 0);
    for (int i = 0; i < v.rsp_wait; i++) begin
      bus.redirect_valid = v.stray;
      bus.redirect_pc    = 32'h8000_0200;
      step();
      check("wait_idle_req", bus.mem_req_valid, 0);
      check("wait_idle_inst", bus.inst_valid, 0);
    end
    bus.redirect_valid = 1'b0;
    bus.mem_rsp_valid  = 1'b1;
    bus.mem_rsp_data   = v.data;
    step();
    bus.mem_rsp_valid  = 1'b0;
    check("inst_valid", bus.inst_valid, 1);
    check("hold_no_req", bus.mem_req_valid, 0);
    for (int i = 0; i < v.hold_stall; i++) begin
      bus.inst_ready     = 1'b0;
      bus.mem_rsp_valid  = 1'b1;
      bus.mem_rsp_data   = ~v.data;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0200;
      step();
      check("hold_valid", bus.inst_valid, 1);
      check("hold_inst", bus.inst, v.data);
      check("hold_pc", bus.inst_pc, v.exp_addr);
    end
    bus.mem_rsp_valid  = 1'b0;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.rpc;
    bus.inst_ready     = 1'b1;
    if (bus.inst_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_inst", bus.inst, e.data);
      check("sb_pc", bus.inst_pc, e.pc);
    end else begin
      checks++;
      errors++;
      $display("FAIL sb_pop inst_valid=%b queued=%0d required inst_valid=1 queued>0",
               bus.inst_valid, sb_q.size());
    end
    step();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    exp_count++;
    if (v.exp_fault) begin
      for (int i = 0; i < 3; i++) begin
        check("fault_flag", bus.fetch_fault, 1);
        check("fault_no_req", bus.mem_req_valid, 0);
        check("fault_no_inst", bus.inst_valid, 0);
        check("fault_inst_pc", bus.inst_pc, v.exp_addr);
        step();
      end
    end else begin
      check("no_fault", bus.fetch_fault, 0);
      check("fetch_count", bus.fetch_count, exp_count);
    end
  endtask

  initial begin
    // exp_addr, req_stall, rsp_wait, hold_stall, redir, rpc, data, exp_fault, stray
    vecs[0] = '{32'h8000_0000, 0, 0, 0, 1'b0, 32'h0, 32'h0010_0093, 1'b0, 1'b0};
    vecs[1] = '{32'h8000_0004, 5, 0, 0, 1'b0, 32'h0, 32'h0020_0113, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0008, 0, 0, 4, 1'b1, 32'h8000_0100, 32'h0F80_006F, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0100, 1, 2, 0, 1'b0, 32'h0, 32'h0030_0193, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0104, 0, 1, 2, 1'b1, 32'hFFFF_FFFC, 32'h0000_8067, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFC, 0, 0, 0, 1'b0, 32'h0, 32'h0040_0213, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 0, 0, 1, 1'b1, 32'h8000_0102, 32'h1020_00E7, 1'b1, 1'b0};
    v0      = vecs[0];

    drive_idle();
    rst = 1'b1;
    step();
    step();
    check("rst_no_req", bus.mem_req_valid, 0);
    check("rst_no_inst", bus.inst_valid, 0);
    check("rst_fault", bus.fetch_fault, 0);
    check("rst_count", bus.fetch_count, 0);
    check("rst_inst", bus.inst, 32'h0000_0013);
    check("rst_inst_pc", bus.inst_pc, 32'h8000_0000);
    rst = 1'b0;
    #1;
    check("first_req", bus.mem_req_valid, 1);

    for (int i = 0; i < 7; i++) begin
      fetch_one(vecs[i]);
    end

    // Access error in WAIT, then recovery through reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    exp_count = 0;
    sb_q.delete();
    check("err_req_addr", bus.mem_req_addr, 32'h8000_0000);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_err   = 1'b1;
    bus.mem_rsp_data  = 32'h0050_0293;
    step();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
    check("err_fault", bus.fetch_fault, 1);
    check("err_no_req", bus.mem_req_valid, 0);
    check("err_no_inst", bus.inst_valid, 0);
    step();
    check("err_stays", bus.fetch_fault, 1);
    check("err_still_no_req", bus.mem_req_valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rec_fault", bus.fetch_fault, 0);
    check("rec_count", bus.fetch_count, 0);
    check("rec_req", bus.mem_req_valid, 1);
    fetch_one(v0);
    check("rec_next_addr", bus.mem_req_addr, 32'h8000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
